// File: rtl/banco_registros.sv
// banco_registros: 2-read / 1-write register file feeding the ALU operands.
//   Reads are combinational. Writes commit on the rising edge of clk.
//   Register 0 always reads as zero.
//   Optional macro REGFILE_DEBUG_EN adds a third combinational read port
//   (dbg_addr/dbg_data) for visibility. The default build has no debug port.
module banco_registros #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [ADDR_W-1:0] a3,
  input  logic [WIDTH-1:0]  wd3,
  input  logic              we3,
`ifdef REGFILE_DEBUG_EN
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data,
`endif
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;

  // Next-state: apply the write port. Entry 0 is pinned to zero so a write
  // to it is dropped and the flop holds a constant.
  always_comb begin
    regs_d = regs_q;
    if (we3 && (a3 != '0)) regs_d[a3] = wd3;
    regs_d[0] = '0;
  end

  // Storage: synchronous reset wins over any write in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  // Read ports: plain lookup of the stored value, with no bypass from wd3.
  // A bypass would close a combinational loop through the ALU and the
  // writeback mux. A same-cycle read therefore sees the old value.
  assign rd1 = (a1 == '0) ? '0 : regs_q[a1];
  assign rd2 = (a2 == '0) ? '0 : regs_q[a2];

`ifdef REGFILE_DEBUG_EN
  assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
`endif

endmodule
